// File: rtl/mac_array_seq.sv
// Sequences a MAC row through one matrix-vector product: clear, feed VEC_LEN operand columns, drain, read out rows.
// Latency: 1 + VEC_LEN + PIPE_LAT + NUM_MAC + 1 cycles from start when unstalled.
// Backpressure: feed stalls while any operand FIFO is empty; readout holds each row until res_ready.
module mac_array_seq #(
    parameter int NUM_MAC  = 8,
    parameter int VEC_LEN  = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    input  logic [NUM_MAC-1:0]                         a_empty,
    input  logic                                       b_empty,
    output logic [NUM_MAC-1:0]                         a_rden,
    output logic                                       b_rden,
    output logic [NUM_MAC-1:0]                         mac_en,
    output logic                                       mac_clr,
    output logic                                       busy,
    output logic                                       res_valid,
    input  logic                                       res_ready,
    output logic [((NUM_MAC > 1) ? $clog2(NUM_MAC) : 1)-1:0] res_sel,
    output logic                                       done
);

    localparam int SEL_W = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1;
    localparam int COL_W = $clog2(VEC_LEN + 1);
    localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_MAC - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(VEC_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        FEED   = 3'd2,
        DRAIN  = 3'd3,
        OUTPUT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic               fire;

    // Pops are all-or-nothing: every A row and B must have data.
    assign fire = ~(|a_empty) & ~b_empty;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_rden    = '0;
        b_rden    = 1'b0;
        mac_en    = '0;
        mac_clr   = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                if (fire) begin
                    a_rden = '1;
                    b_rden = 1'b1;
                    mac_en = '1;
                    if (col_cnt == COL_LAST) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready && (res_sel == SEL_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counters saturate at their terminal values so nothing wraps inside a job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            lat_cnt <= '0;
            res_sel <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    col_cnt <= '0;
                end
                FEED: begin
                    if (fire) begin
                        col_cnt <= col_cnt + COL_W'(1);
                        if (col_cnt == COL_LAST) begin
                            lat_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (lat_cnt == LAT_LAST) begin
                        res_sel <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                OUTPUT: begin
                    if (res_ready && (res_sel != SEL_LAST)) begin
                        res_sel <= res_sel + SEL_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_array_seq.sv
// Directed bench for mac_array_seq with a behavioural MAC row (A[i][j]=i+1, B[j]=2).
module tb_mac_array_seq;

    localparam int NM = 8;
    localparam int VL = 8;
    localparam int PL = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [NM-1:0]  a_empty;
    logic           b_empty;
    logic [NM-1:0]  a_rden;
    logic           b_rden;
    logic [NM-1:0]  mac_en;
    logic           mac_clr;
    logic           busy;
    logic           res_valid;
    logic           res_ready;
    logic [2:0]     res_sel;
    logic           done;

    int    total  = 0;
    int    passed = 0;
    string job_nm = "reset";

    mac_array_seq #(.NUM_MAC(NM), .VEC_LEN(VL), .PIPE_LAT(PL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_empty   (a_empty),
        .b_empty   (b_empty),
        .a_rden    (a_rden),
        .b_rden    (b_rden),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sel   (res_sel),
        .done      (done)
    );

    always #5 clk = ~clk;

    // MAC row: product registered, then accumulated; visible PIPE_LAT cycles after mac_en.
    logic [NM-1:0] v0, v1;
    logic [15:0]   p0 [NM];
    logic [15:0]   p1 [NM];
    logic [15:0]   acc [NM];

    always @(posedge clk) begin
        v0 <= mac_en;
        v1 <= v0;
        for (int i = 0; i < NM; i++) begin
            p0[i] <= 16'((i + 1) * 2);
            p1[i] <= p0[i];
            if (mac_clr) acc[i] <= 16'd0;
            else if (v1[i]) acc[i] <= acc[i] + p1[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", job_nm, tag, obs, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({a_rden, b_rden, mac_en, mac_clr, busy, res_valid, res_sel, done});
    endfunction

    // Cycle 1 is the CLEAR cycle. Inputs change 1 time unit after posedge; outputs sampled at negedge.
    task automatic run_job(input string nm, input int b_lo, input int b_hi, input int a_lo, input int a_hi,
                           input int r_lo, input int r_hi, input int start_at, input int stop_at,
                           input int exp_vld1, input int exp_done, input int exp_vld);
        int clr_n = 0, clr_cyc = -1, first_en = -1, fires = 0, partial = 0, stall_pop = 0;
        int overlap = 0, rows = 0, order_err = 0, cout_err = 0, vld_n = 0, first_vld = -1;
        int done_n = 0, done_cyc = -1, idle_after = 0;
        job_nm = nm;
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            start     = (n == start_at);
            a_empty   = (n >= a_lo && n <= a_hi) ? 8'h20 : 8'h00;
            b_empty   = (n >= b_lo && n <= b_hi);
            res_ready = !(n >= r_lo && n <= r_hi);
            @(negedge clk);
            if (mac_clr) begin
                clr_n++;
                if (clr_cyc < 0) clr_cyc = n;
                if (|mac_en) overlap++;
            end
            if (a_rden !== mac_en || b_rden !== (|mac_en) || (mac_en != '0 && mac_en != '1)) partial++;
            if ((|a_empty || b_empty) && (|a_rden || b_rden || |mac_en)) stall_pop++;
            if (|mac_en) begin
                fires++;
                if (first_en < 0) first_en = n;
            end
            if (res_valid) begin
                vld_n++;
                if (first_vld < 0) first_vld = n;
                if (int'(res_sel) != rows) order_err++;
                if (res_ready) begin
                    if (acc[res_sel] !== 16'(16 * (int'(res_sel) + 1))) cout_err++;
                    rows++;
                end
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (done_cyc > 0 && n == done_cyc + 1 && !busy) idle_after = 1;
            if (n == stop_at) break;
            if (done_cyc > 0 && n >= done_cyc + 2) break;
        end
        start = 1'b0;
        if (stop_at == 0) begin
            chk("clr_count", clr_n, 1);
            chk("clr_cycle", clr_cyc, 1);
            chk("clr_en_overlap", overlap, 0);
            chk("first_en", first_en, 2);
            chk("fires", fires, VL);
            chk("partial_pop", partial, 0);
            chk("pop_in_stall", stall_pop, 0);
            chk("first_valid", first_vld, exp_vld1);
            chk("valid_cycles", vld_n, exp_vld);
            chk("row_order", order_err, 0);
            chk("rows", rows, NM);
            chk("cout", cout_err, 0);
            chk("done_cycle", done_cyc, exp_done);
            chk("done_pulses", done_n, 1);
            chk("idle_after", idle_after, 1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a_empty   = '0;
        b_empty   = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("outs_in_reset", all_outs(), 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_no_pop", all_outs(), 0);
        end

        // Unstalled job: done on cycle 21.
        run_job("full",   0, -1, 0, -1, 0, -1, 0, 0, 13, 21, 8);
        // B empty for 4 cycles after the 3rd fire.
        run_job("b_stall", 5, 8, 0, -1, 0, -1, 0, 0, 17, 25, 8);
        // Single A row empty for 3 cycles.
        run_job("a5_stall", 0, -1, 6, 8, 0, -1, 0, 0, 16, 24, 8);
        // Consumer stalls 5 cycles on row 3.
        run_job("rdy_stall", 0, -1, 0, -1, 16, 20, 0, 0, 13, 26, 13);
        // Extra start during FEED is ignored.
        run_job("start_feed", 0, -1, 0, -1, 0, -1, 5, 0, 13, 21, 8);

        // Abort mid-DRAIN with reset, then a clean job.
        run_job("abort", 0, -1, 0, -1, 0, -1, 0, 11, 0, 0, 0);
        job_nm = "abort";
        chk("drain_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("outs_after_abort", all_outs(), 0);
        @(posedge clk);
        #1;
        chk("outs_held_reset", all_outs(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", all_outs(), 0);
        run_job("post_reset", 0, -1, 0, -1, 0, -1, 0, 0, 13, 21, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
